// File: rtl/cell_sweep_driver.sv
// Standard-cell mux sweep sequencer: walks a range of pages, applies all 64
// input vectors to each page and streams out one 16-bit MISR signature per page.
module cell_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PAGE_FIRST    = 0,
  parameter int unsigned PAGE_LAST     = 31,
  parameter logic [15:0] SEED          = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  page,
  output logic [5:0]  stim,
  output logic        gate,
  input  logic [7:0]  resp,
  output logic [15:0] sig_data,
  output logic [4:0]  sig_page,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PAGE_W = 5;
  localparam int unsigned STIM_W = 6;
  localparam int unsigned SIG_W  = 16;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [PAGE_W-1:0] PFIRST      = PAGE_W'(PAGE_FIRST);
  localparam logic [PAGE_W-1:0] PLAST       = PAGE_W'(PAGE_LAST);
  localparam logic [STIM_W-1:0] STIM_LAST   = STIM_W'(63);
  localparam logic [SIG_W-1:0]  POLY        = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_REPORT,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic [PAGE_W-1:0] page_q;
  logic [STIM_W-1:0] stim_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SIG_W-1:0]  misr_q;
  logic [SIG_W-1:0]  misr_d;
  logic [SIG_W-1:0]  sig_data_q;
  logic [PAGE_W-1:0] sig_page_q;
  logic              sig_valid_q;
  logic              gate_q;
  logic              busy_q;
  logic              done_q;
  logic              sample_c;

  // Signature compaction of the current response into the running MISR
  always_comb begin
    misr_d   = {misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? POLY : '0)
               ^ {8'h00, resp};
    sample_c = (cnt_q == SETTLE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      page_q      <= '0;
      stim_q      <= '0;
      cnt_q       <= '0;
      misr_q      <= '0;
      sig_data_q  <= '0;
      sig_page_q  <= '0;
      sig_valid_q <= 1'b0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Cancel: drop any pending signature but keep its last data/page
        state_q     <= S_IDLE;
        page_q      <= '0;
        stim_q      <= '0;
        cnt_q       <= '0;
        sig_valid_q <= 1'b0;
        gate_q      <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_APPLY;
              page_q  <= PFIRST;
              stim_q  <= '0;
              cnt_q   <= '0;
              misr_q  <= SEED;
              gate_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          S_APPLY: begin
            if (sample_c) begin
              cnt_q  <= '0;
              misr_q <= misr_d;
              if (stim_q == STIM_LAST) begin
                state_q     <= S_REPORT;
                stim_q      <= '0;
                sig_data_q  <= misr_d;
                sig_page_q  <= page_q;
                sig_valid_q <= 1'b1;
              end else begin
                stim_q <= stim_q + STIM_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_REPORT: begin
            if (sig_ready) begin
              sig_valid_q <= 1'b0;
              if (page_q == PLAST) begin
                state_q <= S_FINISH;
              end else begin
                state_q <= S_APPLY;
                page_q  <= page_q + PAGE_W'(1);
                misr_q  <= SEED;
                cnt_q   <= '0;
              end
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            page_q  <= '0;
            stim_q  <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign page      = page_q;
  assign stim      = stim_q;
  assign gate      = gate_q;
  assign sig_data  = sig_data_q;
  assign sig_page  = sig_page_q;
  assign sig_valid = sig_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/cell_sweep_driver.md
# cell_sweep_driver

On-chip stimulus sequencer for the standard-cell mux. It drives the page select, the 6-bit cell inputs and the tristate gate. For each page in a configured range it applies all 64 input vectors and compacts the 8-bit responses into a 16-bit MISR signature. Each finished page's signature is emitted on a valid/ready stream, so the whole cell library can be characterised without external pattern generation.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before the response is sampled (1..15).
- PAGE_FIRST, 0: first page swept (0..31).
- PAGE_LAST, 31: last page swept (PAGE_FIRST..31).
- SEED, 16'hFFFF: MISR value loaded at the start of every page.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel the sweep; synchronous.
- page  out  5  page select to the cell mux.
- stim  out  6  cell input vector.
- gate  out  1  tristate gate enable; 1 while busy.
- resp  in  8  cell mux outputs.
- sig_data  out  16  page signature.
- sig_page  out  5  page number of sig_data.
- sig_valid  out  1  signature available.
- sig_ready  in  1  consumer accepts the signature.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes normally.

## Operation
- All outputs are registered. Reset values are 0 for page, stim, gate, sig_data, sig_page, sig_valid, busy and done.
- States are IDLE, APPLY, REPORT and FINISH.
- IDLE
  - page=0, stim=0, gate=0, busy=0.
  - start=1 → APPLY, with page=PAGE_FIRST, stim=0, MISR=SEED, settle counter=0.
- APPLY
  - busy=1, gate=1. stim is held while the counter runs 0..SETTLE_CYCLES.
  - On the edge where counter==SETTLE_CYCLES, resp is sampled into the MISR: misr ← {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ {8'h00, resp}.
  - On that same edge the counter resets to 0 and stim increments.
  - When stim==63 is sampled → REPORT; the freshly updated MISR value goes to sig_data and the current page to sig_page.
- REPORT
  - sig_valid=1. sig_data, sig_page, page and stim (0) are held stable until sig_ready=1.
  - On the handshake edge (sig_valid & sig_ready), sig_valid drops next cycle.
  - If page==PAGE_LAST → FINISH. Otherwise page increments, MISR=SEED, counter=0 → APPLY.
- FINISH: done=1 for exactly one cycle; busy=0, gate=0; → IDLE.
- Arithmetic: stim and counter never wrap inside a page; page never exceeds PAGE_LAST.
- Boundary rules:
  - start while busy: ignored.
  - start and abort in the same cycle in IDLE: abort wins, no sweep.
  - abort in any non-IDLE state: next cycle is IDLE with page=0, stim=0, gate=0, sig_valid=0, busy=0, and done stays 0. A pending signature is discarded.
  - rst mid-sweep: identical to abort, plus sig_data=0 and sig_page=0.
  - PAGE_FIRST==PAGE_LAST: exactly one signature, then done.
  - sig_ready held at 1: REPORT lasts exactly 1 cycle.

## Timing
- start sampled at edge E0. page/stim are valid from E0 and the first sample is taken at edge E0+SETTLE_CYCLES+1.
- Vector period is SETTLE_CYCLES+1 cycles, so a page's APPLY phase is 64·(SETTLE_CYCLES+1) cycles (192 at the default).
- sig_valid rises on the edge of the 64th sample. Next page's APPLY starts the edge after the handshake.
- With sig_ready=1 always, a page occupies 64·(S+1)+1 cycles. done asserts one cycle after the final handshake.
- The response sampled for vector k corresponds to stim=k. stim changes only on sample edges.

## Test plan
- Single page, zero response: SEED=0, PAGE_FIRST=PAGE_LAST=5, resp=0, sig_ready=1 → exactly one sig_valid pulse with sig_page=5, sig_data=0x0000, then done pulse. busy is high for 194 cycles.
- Last-vector sensitivity: SEED=0, resp=0x01 only while stim==63 → sig_data=0x0001. With resp=0x01 only while stim==62 → sig_data=0x0002.
- Backpressure: full range, sig_ready held low for 10 cycles on page 3 → sig_valid and sig_data stable for all 10 cycles, page=3 and stim=0 held. Sweep resumes; 32 signatures delivered in order with pages 0..31.
- Abort mid-page: abort at stim=20 of page 7 → next cycle busy=0, gate=0, page=0, stim=0, sig_valid=0; no done pulse. A new start restarts at PAGE_FIRST.
- Start/abort precedence and reset: start while busy has no effect on the sequence. start+abort together in IDLE → stays IDLE. rst asserted during REPORT → all outputs 0 next cycle.
- Settle compliance: SETTLE_CYCLES=4; bench changes resp exactly 4 cycles after each stim change → the signature matches the reference model fed the late values. The same stimulus with SETTLE_CYCLES=2 mismatches.
